// File: rtl/bexkat_intctl_pkg.sv
// Shared types and constants for the bexkat vectored interrupt controller.
package bexkat_intctl_pkg;

  // Request/service state of the controller.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INSVC = 2'd2
  } state_e;

  // CSR word addresses.
  localparam logic [1:0] CSR_PENDING = 2'd0;
  localparam logic [1:0] CSR_MASK    = 2'd1;
  localparam logic [1:0] CSR_EDGE    = 2'd2;
  localparam logic [1:0] CSR_VECTOFF = 2'd3;

  // Reset value of the vector-offset register.
  localparam logic [31:0] VECT_RST_DEFAULT = 32'hffffffc0;

endpackage

// File: rtl/bexkat_prio_enc.sv
// Combinational priority encoder: the lowest set index wins.
module bexkat_prio_enc #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [ID_W-1:0]    idx,
  output logic               vld
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/bexkat_intctl.sv
// Vectored interrupt controller for the bexkat CPU family.
// Optional build macro: BEXKAT_INTCTL_NESTED_EN enables nested (preemptive)
// service with a per-line in-service mask; otherwise a single in-service flag.
module bexkat_intctl
  import bexkat_intctl_pkg::*;
#(
  parameter int          NUM_IRQ  = 8,
  parameter int          ID_W     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  parameter logic [31:0] VECT_RST = VECT_RST_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               cyc_i,
  input  logic               we_i,
  input  logic [1:0]         adr_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  output logic               ack_o,
  input  logic               int_en_i,
  output logic               int_req_o,
  output logic [ID_W-1:0]    int_id_o,
  output logic [31:0]        int_vect_o,
  input  logic               int_ack_i,
  input  logic               eoi_i
);

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pend_edge_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] edge_q;
  logic [NUM_IRQ-1:0] blocked;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] set_vec;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] id_oh;
  logic [31:0]        vectoff_q;
  logic [31:0]        rdata;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    win_idx;
  logic               win_vld;
  logic               enter_req;
  logic               ack_fire;
  logic               eoi_fire;
  logic               cyc_q;
  logic               csr_stb;
  logic               csr_wr;

  // Edge lines use the sticky register, level lines follow the synchronised input.
  assign pending  = (edge_q & pend_edge_q) | (~edge_q & irq_q);
  assign eligible = pending & mask_q & ~blocked;

  // A bus cycle is acted on only in its first clock.
  assign csr_stb = cyc_i & ~cyc_q;
  assign csr_wr  = csr_stb & we_i;

  bexkat_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_win_enc (
    .req (eligible),
    .idx (win_idx),
    .vld (win_vld)
  );

`ifdef BEXKAT_INTCTL_NESTED_EN
  logic [NUM_IRQ-1:0] insvc_q;
  logic [NUM_IRQ-1:0] insvc_low;
  logic [NUM_IRQ-1:0] insvc_after;
  logic [ID_W-1:0]    svc_idx;
  logic               svc_vld;

  bexkat_prio_enc #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_svc_enc (
    .req (insvc_q),
    .idx (svc_idx),
    .vld (svc_vld)
  );

  // Block the current handler's line and everything of lower priority.
  always_comb begin
    blocked   = '0;
    insvc_low = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (svc_vld && (ID_W'(i) >= svc_idx)) blocked[i] = 1'b1;
      if (svc_vld && (ID_W'(i) == svc_idx)) insvc_low[i] = 1'b1;
    end
  end

  assign insvc_after = insvc_q & ~insvc_low;

  // In-service mask: ack adds the requested line, eoi retires the innermost one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      insvc_q <= '0;
    end else if (ack_fire) begin
      insvc_q <= insvc_q | id_oh;
    end else if (eoi_fire) begin
      insvc_q <= insvc_after;
    end
  end
`else
  logic insvc_q;

  // No preemption: nothing new is taken while a request or handler is active.
  assign blocked = ((state_q != IDLE) || insvc_q) ? '1 : '0;

  // Single in-service flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      insvc_q <= 1'b0;
    end else if (ack_fire) begin
      insvc_q <= 1'b1;
    end else if (eoi_fire) begin
      insvc_q <= 1'b0;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic and the per-cycle control strobes it implies.
  always_comb begin
    state_d   = state_q;
    enter_req = 1'b0;
    ack_fire  = 1'b0;
    eoi_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (int_en_i && win_vld) begin
          state_d   = REQ;
          enter_req = 1'b1;
        end
      end
      REQ: begin
        if (int_ack_i) begin
          state_d  = INSVC;
          ack_fire = 1'b1;
        end else if (!int_en_i) begin
`ifdef BEXKAT_INTCTL_NESTED_EN
          state_d = (|insvc_q) ? INSVC : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
      INSVC: begin
        if (eoi_i) begin
          eoi_fire = 1'b1;
`ifdef BEXKAT_INTCTL_NESTED_EN
          state_d  = (|insvc_after) ? INSVC : IDLE;
        end else if (int_en_i && win_vld) begin
          state_d   = REQ;
          enter_req = 1'b1;
`else
          state_d  = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs to the core; the vector sum wraps at 32 bits.
  always_comb begin
    int_req_o  = (state_q == REQ);
    int_id_o   = id_q;
    int_vect_o = vectoff_q + {{(30 - ID_W){1'b0}}, id_q, 2'b00};
  end

  // Request ID is captured on entry to REQ and frozen until the next entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        id_q <= '0;
    else if (enter_req) id_q <= win_idx;
  end

  // Rising-edge detection, and clear sources (CSR write-1-clear, acknowledge).
  always_comb begin
    set_vec = edge_q & irq_i & ~irq_q;
    clr_vec = '0;
    id_oh   = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      id_oh[i] = (ID_W'(i) == id_q);
    end
    if (csr_wr && (adr_i == CSR_PENDING)) clr_vec = dat_i[NUM_IRQ-1:0];
    if (ack_fire) clr_vec = clr_vec | (id_oh & edge_q);
  end

  // Input register and sticky edge-pending bits; a same-cycle set beats a clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q       <= '0;
      pend_edge_q <= '0;
    end else begin
      irq_q       <= irq_i;
      pend_edge_q <= ((pend_edge_q & ~clr_vec) | set_vec) & edge_q;
    end
  end

  // CSR read mux; unused upper bits read as zero.
  always_comb begin
    case (adr_i)
      CSR_PENDING: rdata = 32'(pending);
      CSR_MASK:    rdata = 32'(mask_q);
      CSR_EDGE:    rdata = 32'(edge_q);
      default:     rdata = vectoff_q;
    endcase
  end

  // Configuration registers written on the first clock of a bus cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q    <= '0;
      edge_q    <= '0;
      vectoff_q <= {VECT_RST[31:2], 2'b00};
    end else if (csr_wr) begin
      case (adr_i)
        CSR_MASK:    mask_q    <= dat_i[NUM_IRQ-1:0];
        CSR_EDGE:    edge_q    <= dat_i[NUM_IRQ-1:0];
        CSR_VECTOFF: vectoff_q <= {dat_i[31:2], 2'b00};
        default:     ;
      endcase
    end
  end

  // Single-cycle acknowledge with registered read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      cyc_q <= cyc_i;
      ack_o <= csr_stb;
      if (csr_stb) dat_o <= rdata;
    end
  end

endmodule

// File: tb/tb_bexkat_intctl.sv
// Self-checking bench for bexkat_intctl (NUM_IRQ=8).
module tb_bexkat_intctl;
  import bexkat_intctl_pkg::*;

  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;

  logic              clk_i;
  logic              rst_ni;
  logic [NUM_IRQ-1:0] irq_i;
  logic              cyc_i;
  logic              we_i;
  logic [1:0]        adr_i;
  logic [31:0]       dat_i;
  logic [31:0]       dat_o;
  logic              ack_o;
  logic              int_en_i;
  logic              int_req_o;
  logic [ID_W-1:0]   int_id_o;
  logic [31:0]       int_vect_o;
  logic              int_ack_i;
  logic              eoi_i;

  bexkat_intctl #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .irq_i      (irq_i),
    .cyc_i      (cyc_i),
    .we_i       (we_i),
    .adr_i      (adr_i),
    .dat_i      (dat_i),
    .dat_o      (dat_o),
    .ack_o      (ack_o),
    .int_en_i   (int_en_i),
    .int_req_o  (int_req_o),
    .int_id_o   (int_id_o),
    .int_vect_o (int_vect_o),
    .int_ack_i  (int_ack_i),
    .eoi_i      (eoi_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected CSR responses, popped when ack_o is seen.
  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  always @(negedge clk_i) begin : csr_mon
    sb_t e;
    if (rst_ni && ack_o) begin
      if (sb.size() == 0) begin
        check("ack_spurious", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.chk) check(e.name, dat_o, e.exp);
      end
    end
  end

  // All tasks are entered and left just after a falling edge.
  task automatic csr(input logic [1:0] a, input logic wr, input logic [31:0] d,
                     input logic chk, input logic [31:0] exp, input string name);
    sb_t e;
    cyc_i = 1'b1; we_i = wr; adr_i = a; dat_i = d;
    e.chk = chk; e.exp = exp; e.name = name;
    sb.push_back(e);
    @(negedge clk_i);
    check({name, "_ack"}, 32'(ack_o), 32'd1);
    cyc_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr(a, 1'b1, d, 1'b0, 32'd0, "wr");
  endtask

  task automatic csr_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    csr(a, 1'b0, 32'd0, 1'b1, exp, name);
  endtask

  task automatic pulse_irq(input int l);
    irq_i[l] = 1'b1;
    @(negedge clk_i);
    irq_i[l] = 1'b0;
  endtask

  task automatic ack_pulse();
    int_ack_i = 1'b1;
    @(negedge clk_i);
    int_ack_i = 1'b0;
  endtask

  task automatic eoi_pulse();
    eoi_i = 1'b1;
    @(negedge clk_i);
    eoi_i = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_id);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      if (int_req_o) seen = 1'b1;
    end
    check({name, "_req"}, 32'(seen), 32'd1);
    if (seen) check({name, "_id"}, 32'(int_id_o), exp_id);
  endtask

  task automatic quiet(input int n, input string name);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk_i);
      if (int_req_o) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  typedef struct {
    logic [31:0] mask;
    logic [31:0] edge_m;
    logic [31:0] vectoff;
    int          line;
    logic [31:0] exp_vect;
  } vec_t;
  vec_t vecs[6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0c, 32'h08, 32'hffffffc0, 3, 32'hffffffcc};
    vecs[1] = '{32'h01, 32'h01, 32'hffffffc0, 0, 32'hffffffc0};
    vecs[2] = '{32'h80, 32'h80, 32'hffffffc0, 7, 32'hffffffdc};
    vecs[3] = '{32'hf0, 32'hf0, 32'hffffffc0, 4, 32'hffffffd0};
    vecs[4] = '{32'h40, 32'h40, 32'h00001003, 6, 32'h00001018};
    vecs[5] = '{32'h04, 32'h04, 32'hfffffffc, 2, 32'h00000004};

    rst_ni = 1'b0; irq_i = '0; cyc_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0;
    int_en_i = 1'b0; int_ack_i = 1'b0; eoi_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_req", 32'(int_req_o), 32'd0);
    check("rst_id", 32'(int_id_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    csr_rd(CSR_PENDING, 32'h0, "rst_pending");
    csr_rd(CSR_MASK,    32'h0, "rst_mask");
    csr_rd(CSR_EDGE,    32'h0, "rst_edge");
    csr_rd(CSR_VECTOFF, 32'hffffffc0, "rst_vectoff");
    check("rst_req2", 32'(int_req_o), 32'd0);
    int_en_i = 1'b1;

    // Single edge-triggered request per vector, with exact latency.
    for (int i = 0; i < 6; i++) begin
      csr_wr(CSR_MASK, vecs[i].mask);
      csr_wr(CSR_EDGE, vecs[i].edge_m);
      csr_wr(CSR_VECTOFF, vecs[i].vectoff);
      pulse_irq(vecs[i].line);
      check($sformatf("v%0d_lat0", i), 32'(int_req_o), 32'd0);
      @(negedge clk_i);
      check($sformatf("v%0d_req", i), 32'(int_req_o), 32'd1);
      check($sformatf("v%0d_id", i), 32'(int_id_o), 32'(vecs[i].line));
      check($sformatf("v%0d_vect", i), int_vect_o, vecs[i].exp_vect);
      csr_rd(CSR_PENDING, 32'd1 << vecs[i].line, $sformatf("v%0d_pend", i));
      check($sformatf("v%0d_req_held", i), 32'(int_req_o), 32'd1);
      ack_pulse();
      check($sformatf("v%0d_req_drop", i), 32'(int_req_o), 32'd0);
      csr_rd(CSR_PENDING, 32'h0, $sformatf("v%0d_pend_clr", i));
      eoi_pulse();
    end

    // Level lines 2 and 5 held: 2 is served, and served again after eoi.
    csr_wr(CSR_EDGE, 32'h0);
    csr_wr(CSR_MASK, 32'h24);
    csr_wr(CSR_VECTOFF, 32'hffffffc0);
    irq_i = 8'h24;
    wait_req("lvl1", 32'd2);
    check("lvl1_vect", int_vect_o, 32'hffffffc8);
    ack_pulse();
    check("lvl1_drop", 32'(int_req_o), 32'd0);
    csr_wr(CSR_PENDING, 32'h24);
    csr_rd(CSR_PENDING, 32'h24, "lvl_w1c_ignored");
    quiet(3, "lvl_insvc_blk");
    eoi_pulse();
    wait_req("lvl2", 32'd2);
    ack_pulse();
    irq_i = 8'h20;
    eoi_pulse();
    wait_req("lvl3", 32'd5);
    ack_pulse();
    irq_i = 8'h00;
    eoi_pulse();

    // Withdrawal by int_en_i, and ID frozen while masked in REQ.
    csr_wr(CSR_MASK, 32'h02);
    csr_wr(CSR_EDGE, 32'h02);
    pulse_irq(1);
    wait_req("en1", 32'd1);
    csr_wr(CSR_MASK, 32'h00);
    check("frz_req", 32'(int_req_o), 32'd1);
    check("frz_id", 32'(int_id_o), 32'd1);
    csr_wr(CSR_MASK, 32'h02);
    int_en_i = 1'b0;
    @(negedge clk_i);
    check("en0_drop", 32'(int_req_o), 32'd0);
    csr_rd(CSR_PENDING, 32'h02, "en0_pend");
    int_en_i = 1'b1;
    wait_req("en2", 32'd1);
    ack_pulse();
    eoi_pulse();
    csr_rd(CSR_PENDING, 32'h00, "en_pend_clr");

    // Rising edge in the same cycle as a write-1-clear: the set wins.
    csr_wr(CSR_MASK, 32'h00);
    irq_i[1] = 1'b1;
    csr_wr(CSR_PENDING, 32'h02);
    irq_i[1] = 1'b0;
    csr_rd(CSR_PENDING, 32'h02, "set_wins");
    csr_wr(CSR_PENDING, 32'h02);
    csr_rd(CSR_PENDING, 32'h00, "w1c");
    csr_wr(CSR_MASK, 32'hffffffff);
    csr_rd(CSR_MASK, 32'h000000ff, "mask_wide");
    csr_wr(CSR_EDGE, 32'hffffff00);
    csr_rd(CSR_EDGE, 32'h00000000, "edge_wide");
    csr_wr(CSR_VECTOFF, 32'h12345677);
    csr_rd(CSR_VECTOFF, 32'h12345674, "vect_lsb");
    csr_wr(CSR_VECTOFF, 32'hffffffc0);

`ifdef BEXKAT_INTCTL_NESTED_EN
    // Line 0 preempts the handler of line 4; line 6 waits for both eois.
    csr_wr(CSR_MASK, 32'h51);
    csr_wr(CSR_EDGE, 32'h51);
    pulse_irq(4);
    wait_req("n4", 32'd4);
    ack_pulse();
    pulse_irq(0);
    wait_req("n0", 32'd0);
    check("n0_vect", int_vect_o, 32'hffffffc0);
    ack_pulse();
    pulse_irq(6);
    quiet(4, "n_blk6");
    eoi_pulse();
    quiet(4, "n_eoi1_insvc");
    eoi_pulse();
    wait_req("n6", 32'd6);
    ack_pulse();
    eoi_pulse();
`else
    // Line 0 does not preempt the handler of line 4.
    csr_wr(CSR_MASK, 32'h11);
    csr_wr(CSR_EDGE, 32'h11);
    pulse_irq(4);
    wait_req("np4", 32'd4);
    ack_pulse();
    pulse_irq(0);
    quiet(4, "np_no_preempt");
    eoi_pulse();
    wait_req("np0", 32'd0);
    ack_pulse();
    eoi_pulse();
`endif

    // Asynchronous reset in the middle of a request.
    csr_wr(CSR_MASK, 32'h02);
    csr_wr(CSR_EDGE, 32'h02);
    pulse_irq(1);
    wait_req("rmid", 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check("rmid_req", 32'(int_req_o), 32'd0);
    check("rmid_id", 32'(int_id_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    csr_rd(CSR_PENDING, 32'h0, "rmid_pend");
    csr_rd(CSR_MASK, 32'h0, "rmid_mask");
    quiet(3, "rmid_quiet");

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
